// File: rtl/mdr_mem_if.sv
// Memory address/data register pair with a level request/acknowledge handshake
// to external RAM. Reads land in MDR. Writes send MDR to the address in MAR.
// A request that sees no acknowledge within TIMEOUT wait cycles is aborted and flagged.
module mdr_mem_if #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              marin,
    input  logic              mdrin,
    input  logic              rd_start,
    input  logic              wr_start,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] mdr_q,
    output logic [ADDR_W-1:0] mar_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] WR_WAIT = 2'd2;

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mar_d;
    logic [DATA_W-1:0] mdr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // The bus is wider than the address. Only its low ADDR_W bits go into MAR.
    logic unused_bus_hi;
    assign unused_bus_hi = ^bus_in[DATA_W-1:ADDR_W];

    // Next-state logic: register loads, handshake sequencing and timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (marin) mar_d = bus_in[ADDR_W-1:0];
                if (mdrin) mdr_d = bus_in;
                // Read wins when both starts arrive together. The write is dropped.
                if (rd_start) begin
                    state_d  = RD_WAIT;
                    mem_rd_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                end else if (wr_start) begin
                    state_d  = WR_WAIT;
                    mem_wr_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ack) begin
                    if (state_q == RD_WAIT) mdr_d = mem_rdata;
                    state_d  = IDLE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Last allowed wait cycle passed without an ack: abort.
                    state_d  = IDLE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Self-checking bench for mdr_mem_if. At each start the expected {err, mdr} result
// goes into a queue. It is popped and compared when done pulses.
module tb_mdr_mem_if;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              clr;
    logic [DATA_W-1:0] bus_in;
    logic              marin, mdrin, rd_start, wr_start;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mdr_q;
    logic [ADDR_W-1:0] mar_q;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd, mem_wr, busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    // Expected completion: bit 32 is err, bits 31:0 are mdr_q.
    logic [32:0] sb_q[$];

    mdr_mem_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .bus_in   (bus_in),
        .marin    (marin),
        .mdrin    (mdrin),
        .rd_start (rd_start),
        .wr_start (wr_start),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .mdr_q    (mdr_q),
        .mar_q    (mar_q),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input string tag);
        logic [32:0] e;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_mdr"}, 64'(mdr_q), 64'(e[31:0]));
            check({tag, "_err"}, 64'(err), 64'(e[32]));
        end
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int rd_cycles;
        int guard;

        clr = 1'b1; bus_in = '0; marin = 0; mdrin = 0; rd_start = 0; wr_start = 0;
        mem_rdata = '0; mem_ack = 0;
        step();
        step();
        clr = 1'b0;
        check("rst_mar", 64'(mar_q), 64'd0);
        check("rst_mdr", 64'(mdr_q), 64'd0);
        check("rst_flags", 64'({mem_rd, mem_wr, busy, done, err}), 64'd0);

        // 1: MAR load, including truncation of the upper bus bits
        marin = 1; bus_in = 32'h0000_0123;
        step();
        marin = 0;
        check("t1_mar", 64'(mar_q), 64'h123);
        check("t1_addr", 64'(mem_addr), 64'h123);
        check("t1_flags", 64'({mem_rd, mem_wr, busy, done, err}), 64'd0);
        marin = 1; bus_in = 32'hABCD_E1F0;
        step();
        marin = 0;
        check("t1_trunc", 64'(mar_q), 64'h1F0);

        // 2: read acked 3 cycles after mem_rd rises
        marin = 1; bus_in = 32'h10;
        step();
        marin = 0; rd_start = 1;
        sb_q.push_back({1'b0, 32'hDEAD_BEEF});
        step();
        rd_start = 0;
        check("t2_rd_rise", 64'({mem_rd, mem_wr, busy}), 64'b101);
        step();
        step();
        check("t2_rd_held", 64'(mem_rd), 64'd1);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 0;
        expect_done("t2");
        check("t2_rd_drop", 64'(mem_rd), 64'd0);
        step();
        check("t2_done_pulse", 64'(done), 64'd0);

        // 3: write acked on the first wait cycle
        mdrin = 1; bus_in = 32'h1234_5678;
        step();
        mdrin = 0; wr_start = 1;
        sb_q.push_back({1'b0, 32'h1234_5678});
        step();
        wr_start = 0;
        check("t3_wr", 64'({mem_rd, mem_wr}), 64'b01);
        check("t3_wdata", 64'(mem_wdata), 64'h1234_5678);
        check("t3_addr", 64'(mem_addr), 64'h10);
        mem_ack = 1;
        step();
        mem_ack = 0;
        expect_done("t3");
        check("t3_wr_drop", 64'(mem_wr), 64'd0);

        // 4: timeout with no ack, then a rerun acked on the last allowed wait cycle
        rd_start = 1;
        sb_q.push_back({1'b1, 32'h1234_5678});
        step();
        rd_start = 0;
        rd_cycles = 0;
        guard = 0;
        while (!done && guard < 40) begin
            if (mem_rd) rd_cycles++;
            step();
            guard++;
        end
        check("t4_rd_cycles", 64'(rd_cycles), 64'(TIMEOUT));
        expect_done("t4_to");
        check("t4_rd_drop", 64'(mem_rd), 64'd0);
        step();
        check("t4_err_sticky", 64'(err), 64'd1);
        rd_start = 1;
        sb_q.push_back({1'b0, 32'hCAFE_F00D});
        step();
        rd_start = 0;
        check("t4_err_clr", 64'(err), 64'd0);
        repeat (TIMEOUT - 1) step();
        check("t4_rd_still", 64'({mem_rd, done}), 64'b10);
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 0;
        expect_done("t4_late");

        // 5: simultaneous starts, then inputs ignored while busy
        rd_start = 1; wr_start = 1;
        sb_q.push_back({1'b0, 32'h0BAD_C0DE});
        step();
        rd_start = 0; wr_start = 0;
        check("t5_rd_wins", 64'({mem_rd, mem_wr}), 64'b10);
        marin = 1; mdrin = 1; bus_in = 32'h0000_01AA; rd_start = 1; wr_start = 1;
        step();
        marin = 0; mdrin = 0; rd_start = 0; wr_start = 0;
        check("t5_mar_stable", 64'(mar_q), 64'h10);
        check("t5_mdr_stable", 64'(mdr_q), 64'hCAFE_F00D);
        check("t5_no_wr", 64'(mem_wr), 64'd0);
        mem_ack = 1; mem_rdata = 32'h0BAD_C0DE;
        step();
        mem_ack = 0;
        expect_done("t5");
        step();
        check("t5_no_second", 64'({mem_rd, mem_wr, busy}), 64'd0);

        // Ack while idle must be ignored
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 0;
        check("idle_ack_mdr", 64'(mdr_q), 64'h0BAD_C0DE);
        check("idle_ack_done", 64'(done), 64'd0);

        // 6: clear during the second wait cycle of a read
        rd_start = 1;
        step();
        rd_start = 0;
        step();
        clr = 1;
        step();
        clr = 0;
        check("t6_after_clr", 64'({mem_rd, mem_wr, busy, done, err}), 64'd0);
        check("t6_mdr", 64'(mdr_q), 64'd0);
        check("t6_mar", 64'(mar_q), 64'd0);
        mem_ack = 1; mem_rdata = 32'h1111_1111;
        step();
        mem_ack = 0;
        check("t6_late_ack_mdr", 64'(mdr_q), 64'd0);
        check("t6_late_ack_done", 64'({done, mem_rd}), 64'd0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Run-away guard
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
